// File: rtl/uart_prog_loader.sv
// ---------------------------------------------------------------------------
// uart_prog_loader
//   Watches a received UART byte stream for a start frame, then assembles the
//   following bytes into big-endian 32-bit words and writes them into
//   instruction memory at consecutive word addresses, holding the CPU in reset
//   until an end frame arrives.
//
//   Start frame : F0 F0 F0 F0 C2 00 00 00
//   End frame   : 0F 0F 0F 0F C2 00 00 00
//
// Parameters
//   ADDR_W     instruction-memory word address width
//   BASE_ADDR  first word address written after a start frame
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   rx_data     received byte, qualified by rx_valid
//   rx_valid    one-cycle strobe per received byte
//   imem_we     one-cycle write pulse per stored word
//   imem_addr   word address of the write
//   imem_wdata  word written
//   cpu_rst     holds the CPU in reset while the loader owns the memory port
//   busy        load in progress (start-frame match until done)
//   done        one-cycle pulse when the end frame is accepted
//   ovf         sticky: a word was dropped because the address ran out
// ---------------------------------------------------------------------------
module uart_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam logic [63:0] START_FRAME = 64'hF0F0_F0F0_C200_0000;
  localparam logic [31:0] END_WORD    = 32'h0F0F_0F0F;
  localparam logic [31:0] TAIL_WORD   = 32'hC200_0000;

  // One extra address bit: once it sets, the address space is exhausted and
  // further words are dropped instead of wrapping onto low addresses.
  localparam logic [ADDR_W:0] BASE_CNT = (ADDR_W + 1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] ADDR_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    HUNT,  // searching for the start frame
    LOAD,  // storing data words
    PEND   // holding a 0F0F0F0F word that may be the start of the end frame
  } state_t;

  state_t state, state_next;

  logic [55:0]     window;       // last seven bytes seen while hunting
  logic [1:0]      byte_idx;     // position of the next byte within its word
  logic [23:0]     word_buf;     // first three bytes of the word in progress
  logic [31:0]     pend_word;
  logic [ADDR_W:0] addr_cnt;
  logic            defer_valid;  // a word still queued behind a pending flush
  logic [31:0]     defer_word;

  logic [63:0] win_next;
  logic [31:0] new_word;
  logic        start_hit;
  logic        word_done;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        defer_set;
  logic        done_set;
  logic        pend_load;
  logic        pend_clear;

  assign win_next  = {window, rx_data};
  assign new_word  = {word_buf, rx_data};
  assign start_hit = (state == HUNT) && rx_valid && (win_next == START_FRAME);
  assign word_done = (state != HUNT) && rx_valid && (byte_idx == 2'd3);

  // done is included so busy stays high through the done cycle itself.
  assign busy    = (state != HUNT) || done;
  assign cpu_rst = busy;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    wr_req     = 1'b0;
    wr_data    = '0;
    defer_set  = 1'b0;
    done_set   = 1'b0;
    pend_load  = 1'b0;
    pend_clear = 1'b0;

    // A queued word always lands the cycle after a pending flush; a new word
    // cannot complete that soon, so the two never collide.
    if (defer_valid) begin
      wr_req  = 1'b1;
      wr_data = defer_word;
    end

    case (state)
      HUNT: begin
        if (start_hit) state_next = LOAD;
      end
      LOAD: begin
        if (word_done) begin
          if (new_word == END_WORD) begin
            state_next = PEND;
            pend_load  = 1'b1;
          end else begin
            wr_req  = 1'b1;
            wr_data = new_word;
          end
        end
      end
      PEND: begin
        if (word_done) begin
          if (new_word == TAIL_WORD) begin
            state_next = HUNT;
            done_set   = 1'b1;
            pend_clear = 1'b1;
          end else begin
            // Not an end frame after all: flush the held word now, then
            // treat the new word like any other.
            wr_req  = 1'b1;
            wr_data = pend_word;
            if (new_word == END_WORD) begin
              pend_load = 1'b1;
            end else begin
              defer_set  = 1'b1;
              state_next = LOAD;
            end
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window      <= '0;
      byte_idx    <= '0;
      word_buf    <= '0;
      pend_word   <= '0;
      addr_cnt    <= '0;
      defer_valid <= 1'b0;
      defer_word  <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      done        <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      imem_we     <= 1'b0;
      done        <= done_set;
      defer_valid <= defer_set;
      if (defer_set) defer_word <= new_word;

      if (pend_load)       pend_word <= new_word;
      else if (pend_clear) pend_word <= '0;

      if (state != HUNT && rx_valid) begin
        byte_idx <= byte_idx + 2'd1;
        word_buf <= {word_buf[15:0], rx_data};
      end

      if (start_hit) begin
        window   <= '0;
        byte_idx <= '0;
        addr_cnt <= BASE_CNT;
        ovf      <= 1'b0;
      end else if (state == HUNT && rx_valid) begin
        window <= win_next[55:0];
      end

      if (wr_req) begin
        if (addr_cnt[ADDR_W]) begin
          ovf <= 1'b1;
        end else begin
          imem_we    <= 1'b1;
          imem_addr  <= addr_cnt[ADDR_W-1:0];
          imem_wdata <= wr_data;
          addr_cnt   <= addr_cnt + ADDR_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_prog_loader
//   Three loader instances share one byte stream:
//     dut0  ADDR_W=10, BASE_ADDR=0
//     dut1  ADDR_W=2,  BASE_ADDR=0   (overflows after four words)
//     dut2  ADDR_W=4,  BASE_ADDR=12  (non-zero base, overflows after four)
//   Writes and done pulses are captured on the falling edge and compared with
//   a frame-level reference model that works on the whole byte list.
// ---------------------------------------------------------------------------
module tb_uart_prog_loader;

  localparam logic [63:0] START_F = 64'hF0F0_F0F0_C200_0000;
  localparam logic [31:0] END_W   = 32'h0F0F_0F0F;
  localparam logic [31:0] TAIL_W  = 32'hC200_0000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic        we0, cr0, bz0, dn0, ov0;
  logic [9:0]  addr0;
  logic [31:0] wd0;
  logic        we1, cr1, bz1, dn1, ov1;
  logic [1:0]  addr1;
  logic [31:0] wd1;
  logic        we2, cr2, bz2, dn2, ov2;
  logic [3:0]  addr2;
  logic [31:0] wd2;

  uart_prog_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0),
    .cpu_rst(cr0), .busy(bz0), .done(dn0), .ovf(ov0));

  uart_prog_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1),
    .cpu_rst(cr1), .busy(bz1), .done(dn1), .ovf(ov1));

  uart_prog_loader #(.ADDR_W(4), .BASE_ADDR(12)) dut2 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2),
    .cpu_rst(cr2), .busy(bz2), .done(dn2), .ovf(ov2));

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  int base_p[3] = '{0, 0, 12};
  int aw_p[3]   = '{10, 2, 4};

  logic [2:0] ov_v, bz_v;
  assign ov_v = {ov2, ov1, ov0};
  assign bz_v = {bz2, bz1, bz0};

  int   cyc = 0;
  wr_t  cap_q[3][$];
  int   cap_done[3][$];
  wr_t  exp_q[3][$];
  int   exp_done[3];
  bit   exp_ovf[3];
  bit   exp_busy[3];
  int   rst_hi_cnt;
  int   busy_diff_cnt;

  logic [7:0] stim[$];
  int         stim_cyc[$];

  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we0) cap_q[0].push_back('{addr: 32'(addr0), data: wd0, cyc: cyc});
    if (we1) cap_q[1].push_back('{addr: 32'(addr1), data: wd1, cyc: cyc});
    if (we2) cap_q[2].push_back('{addr: 32'(addr2), data: wd2, cyc: cyc});
    if (dn0) cap_done[0].push_back(cyc);
    if (dn1) cap_done[1].push_back(cyc);
    if (dn2) cap_done[2].push_back(cyc);
    if (cr0) rst_hi_cnt <= rst_hi_cnt + 1;
    if (cr0 !== bz0 || cr1 !== bz1 || cr2 !== bz2) busy_diff_cnt <= busy_diff_cnt + 1;
  end

  // ---------------------------------------------------------------- model
  // Frame-level view: find the start frame in the byte list, cut the rest
  // into words, stop at a 0F0F0F0F word immediately followed by C2000000,
  // and store every other word at base, base+1, ... while it fits.
  function automatic void run_model(input int k, input int base, input int aw);
    logic [63:0] win = '0;
    logic [31:0] w, nw;
    longint      addr = 0;
    bit          loading = 1'b0;
    int          i = 0;
    int          n = stim.size();
    exp_q[k].delete();
    exp_done[k] = 0;
    exp_ovf[k]  = 1'b0;
    while (i < n) begin
      if (!loading) begin
        win = {win[55:0], stim[i]};
        i++;
        if (win == START_F) begin
          loading    = 1'b1;
          addr       = base;
          exp_ovf[k] = 1'b0;
          win        = '0;
        end
      end else begin
        if (i + 4 > n) break;
        w = {stim[i], stim[i+1], stim[i+2], stim[i+3]};
        i += 4;
        if (w == END_W && i + 4 > n) break;
        nw = (w == END_W) ? {stim[i], stim[i+1], stim[i+2], stim[i+3]} : '0;
        if (w == END_W && nw == TAIL_W) begin
          i += 4;
          exp_done[k]++;
          loading = 1'b0;
        end else if (addr <= (longint'(1) << aw) - 1) begin
          exp_q[k].push_back('{addr: 32'(addr), data: w, cyc: 0});
          addr++;
        end else begin
          exp_ovf[k] = 1'b1;
        end
      end
    end
    exp_busy[k] = loading;
  endfunction

  // ---------------------------------------------------------------- stimulus
  task automatic clear_caps();
    for (int k = 0; k < 3; k++) begin
      cap_q[k].delete();
      cap_done[k].delete();
    end
    rst_hi_cnt    = 0;
    busy_diff_cnt = 0;
    stim.delete();
    stim_cyc.delete();
  endtask

  task automatic apply_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_caps();
  endtask

  task automatic push_word(input logic [31:0] w);
    stim.push_back(w[31:24]);
    stim.push_back(w[23:16]);
    stim.push_back(w[15:8]);
    stim.push_back(w[7:0]);
  endtask

  task automatic push_start();
    push_word(32'hF0F0_F0F0);
    push_word(TAIL_W);
  endtask

  task automatic push_end();
    push_word(END_W);
    push_word(TAIL_W);
  endtask

  // gap < 0 picks a random 0..3 idle cycles after each byte.
  task automatic send_range(input int from, input int to, input int gap);
    int g;
    for (int i = from; i < to; i++) begin
      @(posedge clk);
      #1 rx_data = stim[i];
      rx_valid = 1'b1;
      stim_cyc.push_back(cyc);
      g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
      if (g > 0) begin
        @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (g - 1) @(posedge clk);
      end
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_all(input int gap);
    send_range(0, stim.size(), gap);
    idle(6);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    apply_reset();
    checks++;
    if ({we0, cr0, bz0, dn0, ov0} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got we/cpu_rst/busy/done/ovf=%b expected 00000", {we0, cr0, bz0, dn0, ov0});
    end
    checks++;
    if (addr0 !== 10'd0 || addr2 !== 4'd0) begin
      errors++;
      $display("FAIL reset_addr: got %0d/%0d expected 0/0", addr0, addr2);
    end
    checks++;
    if (wd0 !== 32'd0) begin
      errors++;
      $display("FAIL reset_wdata: got %08h expected 00000000", wd0);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    push_start();
    push_word(32'h0000_0000);
    push_word(32'h27BD_FFF0);
    push_word(32'hAFBE_000C);
    push_end();
    send_all(1);
    for (int k = 0; k < 3; k++) begin
      run_model(k, base_p[k], aw_p[k]);
      checks++;
      if (cap_q[k].size() !== exp_q[k].size()) begin
        errors++;
        $display("FAIL basic_count dut%0d: got %0d writes expected %0d", k, cap_q[k].size(), exp_q[k].size());
      end
      for (int j = 0; j < exp_q[k].size() && j < cap_q[k].size(); j++) begin
        checks++;
        if (cap_q[k][j].addr !== exp_q[k][j].addr || cap_q[k][j].data !== exp_q[k][j].data) begin
          errors++;
          $display("FAIL basic_write dut%0d #%0d: got %0d:%08h expected %0d:%08h", k, j, cap_q[k][j].addr, cap_q[k][j].data, exp_q[k][j].addr, exp_q[k][j].data);
        end
      end
      checks++;
      if (cap_done[k].size() !== exp_done[k] || ov_v[k] !== exp_ovf[k] || bz_v[k] !== exp_busy[k]) begin
        errors++;
        $display("FAIL basic_status dut%0d: got done=%0d ovf=%b busy=%b expected done=%0d ovf=%b busy=%b", k, cap_done[k].size(), ov_v[k], bz_v[k], exp_done[k], exp_ovf[k], exp_busy[k]);
      end
    end
    // First data word ends at byte 11, end frame at byte 27, match at byte 7.
    checks++;
    if (cap_q[0].size() == 0 || cap_q[0][0].cyc !== stim_cyc[11] + 1) begin
      errors++;
      $display("FAIL basic_write_latency: got cycle %0d expected %0d", (cap_q[0].size() == 0) ? -1 : cap_q[0][0].cyc, stim_cyc[11] + 1);
    end
    checks++;
    if (cap_done[0].size() != 1 || cap_done[0][0] !== stim_cyc[27] + 1) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d pulses first at %0d expected 1 at %0d", cap_done[0].size(), (cap_done[0].size() == 0) ? -1 : cap_done[0][0], stim_cyc[27] + 1);
    end
    checks++;
    if (rst_hi_cnt !== stim_cyc[27] + 1 - stim_cyc[7]) begin
      errors++;
      $display("FAIL basic_cpu_rst_span: got %0d cycles expected %0d", rst_hi_cnt, stim_cyc[27] + 1 - stim_cyc[7]);
    end
    checks++;
    if (busy_diff_cnt !== 0 || cr0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_cpu_rst: got busy/cpu_rst differ %0d cycles, cpu_rst=%b after, expected 0 and 0", busy_diff_cnt, cr0);
    end
  endtask

  task automatic test_garbage();
    apply_reset();
    stim.push_back(8'h12);
    stim.push_back(8'hF0);
    stim.push_back(8'hF0);
    push_start();
    for (int i = 0; i < 3; i++) push_word($urandom);
    push_end();
    send_all(-1);
    checks++;
    if (cap_q[0].size() > 0 && cap_q[0][0].cyc <= stim_cyc[10]) begin
      errors++;
      $display("FAIL garbage_early_write: got write at cycle %0d expected after %0d", cap_q[0][0].cyc, stim_cyc[10]);
    end
    for (int k = 0; k < 3; k++) begin
      run_model(k, base_p[k], aw_p[k]);
      checks++;
      if (cap_q[k].size() !== exp_q[k].size()) begin
        errors++;
        $display("FAIL garbage_count dut%0d: got %0d writes expected %0d", k, cap_q[k].size(), exp_q[k].size());
      end
      for (int j = 0; j < exp_q[k].size() && j < cap_q[k].size(); j++) begin
        checks++;
        if (cap_q[k][j].addr !== exp_q[k][j].addr || cap_q[k][j].data !== exp_q[k][j].data) begin
          errors++;
          $display("FAIL garbage_write dut%0d #%0d: got %0d:%08h expected %0d:%08h", k, j, cap_q[k][j].addr, cap_q[k][j].data, exp_q[k][j].addr, exp_q[k][j].data);
        end
      end
      checks++;
      if (cap_done[k].size() !== exp_done[k] || ov_v[k] !== exp_ovf[k] || bz_v[k] !== exp_busy[k]) begin
        errors++;
        $display("FAIL garbage_status dut%0d: got done=%0d ovf=%b busy=%b expected done=%0d ovf=%b busy=%b", k, cap_done[k].size(), ov_v[k], bz_v[k], exp_done[k], exp_ovf[k], exp_busy[k]);
      end
    end
  endtask

  task automatic test_pending();
    apply_reset();
    push_start();
    push_word($urandom);
    push_word(END_W);
    push_word(32'h1122_3344);
    push_word($urandom);
    send_all(2);
    for (int k = 0; k < 3; k++) begin
      run_model(k, base_p[k], aw_p[k]);
      checks++;
      if (cap_q[k].size() !== exp_q[k].size()) begin
        errors++;
        $display("FAIL pending_count dut%0d: got %0d writes expected %0d", k, cap_q[k].size(), exp_q[k].size());
      end
      for (int j = 0; j < exp_q[k].size() && j < cap_q[k].size(); j++) begin
        checks++;
        if (cap_q[k][j].addr !== exp_q[k][j].addr || cap_q[k][j].data !== exp_q[k][j].data) begin
          errors++;
          $display("FAIL pending_write dut%0d #%0d: got %0d:%08h expected %0d:%08h", k, j, cap_q[k][j].addr, cap_q[k][j].data, exp_q[k][j].addr, exp_q[k][j].data);
        end
      end
      checks++;
      if (cap_done[k].size() !== 0 || bz_v[k] !== 1'b1) begin
        errors++;
        $display("FAIL pending_status dut%0d: got done=%0d busy=%b expected done=0 busy=1", k, cap_done[k].size(), bz_v[k]);
      end
    end
    // The held word and the word after it land on consecutive cycles.
    checks++;
    if (cap_q[0].size() < 3 || cap_q[0][1].cyc !== stim_cyc[19] + 1 || cap_q[0][2].cyc !== stim_cyc[19] + 2) begin
      errors++;
      $display("FAIL pending_timing: got %0d writes, cycles %0d/%0d expected %0d/%0d", cap_q[0].size(), (cap_q[0].size() < 3) ? -1 : cap_q[0][1].cyc, (cap_q[0].size() < 3) ? -1 : cap_q[0][2].cyc, stim_cyc[19] + 1, stim_cyc[19] + 2);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    push_start();
    for (int i = 0; i < 6; i++) push_word($urandom);
    push_end();
    send_range(0, 24, 1);
    idle(3);
    checks++;
    if (ov1 !== 1'b0 || ov2 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_after_4: got %b/%b expected 0/0", ov1, ov2);
    end
    send_range(24, 28, 1);
    idle(3);
    checks++;
    if (ov1 !== 1'b1 || ov2 !== 1'b1 || ov0 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_after_5: got dut0/1/2=%b/%b/%b expected 0/1/1", ov0, ov1, ov2);
    end
    send_range(28, stim.size(), 1);
    idle(6);
    for (int k = 0; k < 3; k++) begin
      run_model(k, base_p[k], aw_p[k]);
      checks++;
      if (cap_q[k].size() !== exp_q[k].size()) begin
        errors++;
        $display("FAIL ovf_count dut%0d: got %0d writes expected %0d", k, cap_q[k].size(), exp_q[k].size());
      end
      for (int j = 0; j < exp_q[k].size() && j < cap_q[k].size(); j++) begin
        checks++;
        if (cap_q[k][j].addr !== exp_q[k][j].addr || cap_q[k][j].data !== exp_q[k][j].data) begin
          errors++;
          $display("FAIL ovf_write dut%0d #%0d: got %0d:%08h expected %0d:%08h", k, j, cap_q[k][j].addr, cap_q[k][j].data, exp_q[k][j].addr, exp_q[k][j].data);
        end
      end
      checks++;
      if (cap_done[k].size() !== exp_done[k] || ov_v[k] !== exp_ovf[k] || bz_v[k] !== exp_busy[k]) begin
        errors++;
        $display("FAIL ovf_status dut%0d: got done=%0d ovf=%b busy=%b expected done=%0d ovf=%b busy=%b", k, cap_done[k].size(), ov_v[k], bz_v[k], exp_done[k], exp_ovf[k], exp_busy[k]);
      end
    end
  endtask

  task automatic test_reset_midload();
    apply_reset();
    push_start();
    push_word($urandom | 32'h8000_0000);
    stim.push_back(8'hAB);
    stim.push_back(8'hCD);
    send_all(1);
    checks++;
    if (bz0 !== 1'b1 || cap_q[0].size() !== 1) begin
      errors++;
      $display("FAIL midload_before: got busy=%b writes=%0d expected busy=1 writes=1", bz0, cap_q[0].size());
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({we0, cr0, bz0, dn0, ov0} !== 5'b0 || addr2 !== 4'd0 || wd0 !== 32'd0 || wd2 !== 32'd0) begin
      errors++;
      $display("FAIL midload_async_reset: got flags=%b addr2=%0d wd0=%08h wd2=%08h expected all zero", {we0, cr0, bz0, dn0, ov0}, addr2, wd0, wd2);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_caps();
    stim.push_back(8'($urandom));
    stim.push_back(8'($urandom));
    push_word($urandom);
    push_start();
    push_word($urandom);
    push_word($urandom);
    push_end();
    send_all(-1);
    for (int k = 0; k < 3; k++) begin
      run_model(k, base_p[k], aw_p[k]);
      checks++;
      if (cap_q[k].size() !== exp_q[k].size()) begin
        errors++;
        $display("FAIL midload_count dut%0d: got %0d writes expected %0d", k, cap_q[k].size(), exp_q[k].size());
      end
      for (int j = 0; j < exp_q[k].size() && j < cap_q[k].size(); j++) begin
        checks++;
        if (cap_q[k][j].addr !== exp_q[k][j].addr || cap_q[k][j].data !== exp_q[k][j].data) begin
          errors++;
          $display("FAIL midload_write dut%0d #%0d: got %0d:%08h expected %0d:%08h", k, j, cap_q[k][j].addr, cap_q[k][j].data, exp_q[k][j].addr, exp_q[k][j].data);
        end
      end
      checks++;
      if (cap_done[k].size() !== exp_done[k] || ov_v[k] !== exp_ovf[k] || bz_v[k] !== exp_busy[k]) begin
        errors++;
        $display("FAIL midload_status dut%0d: got done=%0d ovf=%b busy=%b expected done=%0d ovf=%b busy=%b", k, cap_done[k].size(), ov_v[k], bz_v[k], exp_done[k], exp_ovf[k], exp_busy[k]);
      end
    end
  endtask

  // Two loads in one stream, including a start frame carried as data, a
  // lone 0F0F0F0F data word and a 0F0F0F0F directly before the end frame.
  // The stream is played spaced, then again with rx_valid every cycle.
  task automatic test_back_to_back();
    logic [7:0] saved_stim[$];
    wr_t        spaced[$];
    apply_reset();
    for (int i = 0; i < 3; i++) stim.push_back(8'($urandom));
    push_start();
    for (int i = 0; i < 4; i++) push_word($urandom);
    push_word(END_W);
    push_word($urandom);
    push_start();
    push_word(END_W);
    push_end();
    stim.push_back(8'($urandom));
    stim.push_back(8'($urandom));
    push_start();
    push_word($urandom);
    push_word($urandom);
    push_end();
    saved_stim = stim;
    send_all(-1);
    spaced = cap_q[0];
    apply_reset();
    stim = saved_stim;
    send_all(0);
    for (int k = 0; k < 3; k++) begin
      run_model(k, base_p[k], aw_p[k]);
      checks++;
      if (cap_q[k].size() !== exp_q[k].size()) begin
        errors++;
        $display("FAIL b2b_count dut%0d: got %0d writes expected %0d", k, cap_q[k].size(), exp_q[k].size());
      end
      for (int j = 0; j < exp_q[k].size() && j < cap_q[k].size(); j++) begin
        checks++;
        if (cap_q[k][j].addr !== exp_q[k][j].addr || cap_q[k][j].data !== exp_q[k][j].data) begin
          errors++;
          $display("FAIL b2b_write dut%0d #%0d: got %0d:%08h expected %0d:%08h", k, j, cap_q[k][j].addr, cap_q[k][j].data, exp_q[k][j].addr, exp_q[k][j].data);
        end
      end
      checks++;
      if (cap_done[k].size() !== exp_done[k] || ov_v[k] !== exp_ovf[k] || bz_v[k] !== exp_busy[k]) begin
        errors++;
        $display("FAIL b2b_status dut%0d: got done=%0d ovf=%b busy=%b expected done=%0d ovf=%b busy=%b", k, cap_done[k].size(), ov_v[k], bz_v[k], exp_done[k], exp_ovf[k], exp_busy[k]);
      end
    end
    checks++;
    if (spaced.size() !== exp_q[0].size()) begin
      errors++;
      $display("FAIL b2b_spaced_count: got %0d writes expected %0d", spaced.size(), exp_q[0].size());
    end
    for (int j = 0; j < spaced.size() && j < exp_q[0].size(); j++) begin
      checks++;
      if (spaced[j].addr !== exp_q[0][j].addr || spaced[j].data !== exp_q[0][j].data) begin
        errors++;
        $display("FAIL b2b_spaced_write #%0d: got %0d:%08h expected %0d:%08h", j, spaced[j].addr, spaced[j].data, exp_q[0][j].addr, exp_q[0][j].data);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_basic();
    test_garbage();
    test_pending();
    test_overflow();
    test_reset_midload();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning width of the instruction-memory word address.
REQ-002 SHALL have parameter BASE_ADDR, default 0, meaning the first word address written after a start frame.
REQ-003 SHALL have port clk  input  1  meaning single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  meaning received UART byte, valid only when rx_valid=1.
REQ-006 SHALL have port rx_valid  input  1  meaning one-cycle strobe, one per received byte.
REQ-007 SHALL have port imem_we  output  1  meaning instruction-memory write enable, one-cycle pulse per word.
REQ-008 SHALL have port imem_addr  output  ADDR_W  meaning instruction-memory word address.
REQ-009 SHALL have port imem_wdata  output  32  meaning instruction word to write.
REQ-010 SHALL have port cpu_rst  output  1  meaning hold-CPU-in-reset while loading; the memory write port belongs to the loader while it is 1.
REQ-011 SHALL have port busy  output  1  meaning load in progress, from start-frame detection until end-frame acceptance.
REQ-012 SHALL have port done  output  1  meaning one-cycle pulse when the end frame is accepted.
REQ-013 SHALL have port ovf  output  1  meaning sticky flag: at least one word was dropped due to address overflow.

Function
REQ-014 SHALL define the start frame as the bytes F0 F0 F0 F0 C2 00 00 00 and the end frame as 0F 0F 0F 0F C2 00 00 00, in arrival order.
REQ-015 SHALL implement states HUNT, LOAD, PEND; the reset state is HUNT.
REQ-016 In HUNT, SHALL compare an 8-byte sliding window of the last received bytes against the start frame on every rx_valid; a match enters LOAD with byte index 0, address = BASE_ADDR, and ovf cleared.
REQ-017 In HUNT, SHALL ignore all other bytes and generate no writes.
REQ-018 In LOAD/PEND, SHALL assemble words big-endian, word-aligned: the first byte after a frame is bits 31:24 and the 4th byte is bits 7:0.
REQ-019 In LOAD, on completion of a word other than 0F0F0F0F, SHALL assert imem_we on the cycle after the 4th byte's rx_valid, with imem_wdata equal to the word and imem_addr equal to the current address, then increment the address.
REQ-020 In LOAD, on completion of word 0F0F0F0F, SHALL latch it as pending without writing and enter PEND.
REQ-021 In PEND, when the next completed word equals C2000000, SHALL discard both words, return to HUNT, and pulse done in that same cycle.
REQ-022 In PEND, when the next completed word differs from C2000000, SHALL write the pending word at the current address.
REQ-023 SHALL then handle the new word under REQ-019 or REQ-020, writing it in the following cycle if applicable, so that no word is lost and order is preserved.
REQ-024 SHALL keep imem_we low in all cycles except write cycles; imem_addr and imem_wdata hold their last values otherwise.
REQ-025 When the address would exceed 2^ADDR_W-1, SHALL suppress imem_we for that word, set ovf, and not wrap the address.
REQ-026 SHALL keep cpu_rst = busy = 1 from the cycle after the start-frame match until the cycle done pulses; both SHALL be 0 from the cycle after done.
REQ-027 A new start frame received during LOAD SHALL be treated as data; only the end frame terminates a load.
REQ-028 rx_valid pulses SHALL be accepted back-to-back (every cycle) without loss.

Reset
REQ-029 On rst=1, SHALL immediately enter HUNT, clear the sliding window, the byte index, the pending word and the address, and drive imem_we=0, cpu_rst=0, busy=0, done=0, ovf=0, imem_addr=0, imem_wdata=0.
REQ-030 A reset mid-load SHALL abandon the load; words already written SHALL remain in memory, and no further writes SHALL occur until a new start frame arrives.

Verification
REQ-031 Start frame, then 00000000, 27BDFFF0, AFBE000C, then end frame -> three writes at addresses 0,1,2 with data 00000000, 27BDFFF0, AFBE000C; one done pulse; cpu_rst high throughout and low afterwards.
REQ-032 Garbage bytes 12 F0 F0 before the start frame -> no writes until the frame completes; the first write is at address BASE_ADDR.
REQ-033 Data word 0F0F0F0F followed by 11223344 -> writes 0F0F0F0F at address n and 11223344 at address n+1 on consecutive cycles; no done pulse.
REQ-034 With ADDR_W=2, six data words -> four writes at addresses 0-3; ovf=1 after the 5th word; the end frame still produces a done pulse.
REQ-035 rst asserted after the 2nd byte of a word -> outputs return to reset values immediately; a later full frame sequence loads correctly from BASE_ADDR.
REQ-036 All bytes delivered with rx_valid high every cycle -> results identical to the spaced-stimulus run.
